// File: rtl/fetch_stage.sv
// Program counter and IF/ID pipeline register for the RV32 core.
// Handles stall, redirect/flush and out-of-range fetch faults.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;

  assign imem_pc  = pc;
  assign pc_plus4 = pc + 32'd4;
  assign in_range = (pc <= LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= 32'd4;
      ifid_inst     <= NOP_INST;
      ifid_valid    <= 1'b0;
      fetch_fault   <= 1'b0;
    end else if (redirect) begin
      // Target is word-aligned by masking; the word fetched this cycle is squashed.
      pc            <= redirect_pc & ~32'h3;
      ifid_pc       <= pc;
      ifid_pc_plus4 <= pc_plus4;
      ifid_inst     <= NOP_INST;
      ifid_valid    <= 1'b0;
      fetch_fault   <= 1'b0;
    end else if (stall) begin
      fetch_fault   <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_pc       <= pc;
      ifid_pc_plus4 <= pc_plus4;
      if (in_range) begin
        ifid_inst   <= imem_inst;
        ifid_valid  <= 1'b1;
        fetch_fault <= 1'b0;
      end else begin
        ifid_inst   <= NOP_INST;
        ifid_valid  <= 1'b0;
        fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small combinational
// instruction memory holding a loop program.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        fetch_fault;

  logic [31:0] mem [256];
  logic [31:0] prog [6];
  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LAST = 32'h0FF0_0F13;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(1024),
    .NOP_INST  (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_pc      (imem_pc),
    .imem_inst    (imem_inst),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_inst    (ifid_inst),
    .ifid_valid   (ifid_valid),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  assign imem_inst = (imem_pc < 32'd1024) ? mem[imem_pc[9:2]] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 3; i++) tick();
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL rst_imem_pc got=%h exp=%h", imem_pc, 32'h0); end
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL rst_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
    total++; if (ifid_pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_plus4 got=%h exp=%h", ifid_pc_plus4, 32'h4); end
    total++; if (ifid_inst !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", ifid_inst, NOP); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    reset = 1'b0;
    tick();
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL first_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
    total++; if (ifid_inst !== 32'h0080_0113) begin bad++; $display("FAIL first_inst got=%h exp=%h", ifid_inst, 32'h0080_0113); end
    total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", ifid_valid); end
    total++; if (imem_pc !== 32'h4) begin bad++; $display("FAIL first_imem_pc got=%h exp=%h", imem_pc, 32'h4); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i < 5; i++) begin
      tick();
      total++; if (ifid_pc !== 32'(4 * i)) begin bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, ifid_pc, 32'(4 * i)); end
      total++; if (ifid_pc_plus4 !== 32'(4 * i + 4)) begin bad++; $display("FAIL run_plus4[%0d] got=%h exp=%h", i, ifid_pc_plus4, 32'(4 * i + 4)); end
      total++; if (ifid_inst !== prog[i]) begin bad++; $display("FAIL run_inst[%0d] got=%h exp=%h", i, ifid_inst, prog[i]); end
    end
    total++; if (imem_pc !== 32'd20) begin bad++; $display("FAIL run_imem_pc got=%h exp=%h", imem_pc, 32'd20); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect = 1'b0;
    total++; if (imem_pc !== 32'h4) begin bad++; $display("FAIL redir_imem_pc got=%h exp=%h", imem_pc, 32'h4); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", ifid_valid); end
    total++; if (ifid_inst !== NOP) begin bad++; $display("FAIL redir_inst got=%h exp=%h", ifid_inst, NOP); end
    tick();
    total++; if (ifid_pc !== 32'h4) begin bad++; $display("FAIL redir_next_pc got=%h exp=%h", ifid_pc, 32'h4); end
    total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL redir_next_valid got=%b exp=1", ifid_valid); end
    total++; if (ifid_inst !== prog[1]) begin bad++; $display("FAIL redir_next_inst got=%h exp=%h", ifid_inst, prog[1]); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (imem_pc !== 32'h8) begin bad++; $display("FAIL stall_imem_pc[%0d] got=%h exp=%h", i, imem_pc, 32'h8); end
      total++; if (ifid_pc !== 32'h4) begin bad++; $display("FAIL stall_ifid_pc[%0d] got=%h exp=%h", i, ifid_pc, 32'h4); end
      total++; if (ifid_inst !== prog[1]) begin bad++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, ifid_inst, prog[1]); end
      total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ifid_valid); end
    end
    stall = 1'b0;
    tick();
    total++; if (ifid_pc !== 32'h8) begin bad++; $display("FAIL unstall_pc got=%h exp=%h", ifid_pc, 32'h8); end
    total++; if (ifid_inst !== prog[2]) begin bad++; $display("FAIL unstall_inst got=%h exp=%h", ifid_inst, prog[2]); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_000E;
    tick();
    stall = 1'b0; redirect = 1'b0;
    total++; if (imem_pc !== 32'hC) begin bad++; $display("FAIL sr_imem_pc got=%h exp=%h", imem_pc, 32'hC); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL sr_valid got=%b exp=0", ifid_valid); end
    total++; if (ifid_inst !== NOP) begin bad++; $display("FAIL sr_inst got=%h exp=%h", ifid_inst, NOP); end
    tick();
    total++; if (ifid_pc !== 32'hC) begin bad++; $display("FAIL sr_next_pc got=%h exp=%h", ifid_pc, 32'hC); end
    total++; if (ifid_inst !== prog[3]) begin bad++; $display("FAIL sr_next_inst got=%h exp=%h", ifid_inst, prog[3]); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_pc = 32'h7;
    tick();
    redirect = 1'b0;
    total++; if (imem_pc !== 32'h4) begin bad++; $display("FAIL b2b_imem_pc got=%h exp=%h", imem_pc, 32'h4); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b exp=0", ifid_valid); end
    tick();
    total++; if (ifid_pc !== 32'h4) begin bad++; $display("FAIL b2b_next_pc got=%h exp=%h", ifid_pc, 32'h4); end
    total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL b2b_next_valid got=%b exp=1", ifid_valid); end
  endtask

  task automatic test_boundary();
    redirect = 1'b1; redirect_pc = 32'h3FC;
    tick();
    redirect = 1'b0;
    tick();
    total++; if (ifid_inst !== LAST) begin bad++; $display("FAIL last_inst got=%h exp=%h", ifid_inst, LAST); end
    total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL last_valid got=%b exp=1", ifid_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL last_fault got=%b exp=0", fetch_fault); end
    total++; if (imem_pc !== 32'd1024) begin bad++; $display("FAIL last_imem_pc got=%h exp=%h", imem_pc, 32'd1024); end
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 32'd1024;
    tick();
    redirect = 1'b0;
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL flt_redir_fault got=%b exp=0", fetch_fault); end
    tick();
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL flt_fault got=%b exp=1", fetch_fault); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL flt_valid got=%b exp=0", ifid_valid); end
    total++; if (ifid_inst !== NOP) begin bad++; $display("FAIL flt_inst got=%h exp=%h", ifid_inst, NOP); end
    total++; if (imem_pc !== 32'd1028) begin bad++; $display("FAIL flt_imem_pc got=%h exp=%h", imem_pc, 32'd1028); end
    total++; if (ifid_pc !== 32'd1024) begin bad++; $display("FAIL flt_ifid_pc got=%h exp=%h", ifid_pc, 32'd1024); end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL flt_pulse got=%b exp=0", fetch_fault); end
    total++; if (imem_pc !== 32'd1028) begin bad++; $display("FAIL flt_stall_pc got=%h exp=%h", imem_pc, 32'd1028); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    total++; if (imem_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_imem_pc got=%h exp=%h", imem_pc, 32'hFFFF_FFFC); end
    tick();
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", imem_pc, 32'h0); end
    total++; if (ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=%h", ifid_pc_plus4, 32'h0); end
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL wrap_fault got=%b exp=1", fetch_fault); end
    tick();
    total++; if (ifid_inst !== prog[0]) begin bad++; $display("FAIL wrap_inst got=%h exp=%h", ifid_inst, prog[0]); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL wrap_fault_clr got=%b exp=0", fetch_fault); end
  endtask

  task automatic test_mid_reset();
    redirect = 1'b1; redirect_pc = 32'd1024;
    tick();
    redirect = 1'b0;
    tick();
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL mr_pre_fault got=%b exp=1", fetch_fault); end
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL mr_imem_pc got=%h exp=%h", imem_pc, 32'h0); end
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL mr_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
    total++; if (ifid_pc_plus4 !== 32'h4) begin bad++; $display("FAIL mr_plus4 got=%h exp=%h", ifid_pc_plus4, 32'h4); end
    total++; if (ifid_inst !== NOP) begin bad++; $display("FAIL mr_inst got=%h exp=%h", ifid_inst, NOP); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", ifid_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL mr_fault got=%b exp=0", fetch_fault); end
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL mr_first_pc got=%h exp=%h", ifid_pc, 32'h0); end
    total++; if (ifid_inst !== prog[0]) begin bad++; $display("FAIL mr_first_inst got=%h exp=%h", ifid_inst, prog[0]); end
    total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL mr_first_valid got=%b exp=1", ifid_valid); end
  endtask

  initial begin
    prog[0] = 32'h0080_0113;
    prog[1] = 32'h0010_8093;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'hFFC1_0113;
    prog[4] = 32'hFE01_16E3;
    prog[5] = 32'h0000_006F;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
    mem[255] = LAST;

    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_back_to_back();
    test_boundary();
    test_fault();
    test_wrap();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
